// File: rtl/ray_gen_if.sv
// FIFO write-side bundle between ray_gen and fifo_array.
// dout index 0 = x, 1 = y, 2 = z; full must be registered in the FIFO.
interface ray_gen_if;
    logic        wr_en;
    logic        full;
    logic [31:0] dout [3];

    modport master (
        output wr_en,
        output dout,
        input  full
    );

    modport slave (
        input  wr_en,
        input  dout,
        output full
    );
endinterface

// File: rtl/ray_gen.sv
// Camera-ray direction generator: one Q-format {x,y,z} vector per pixel.
// Define RAY_GEN_SERPENTINE_EN for boustrophedon (odd rows right-to-left).
module ray_gen #(
    parameter int Q_BITS = 10,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 48
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] x_start,
    input  logic [31:0] y_start,
    input  logic [31:0] step,
    ray_gen_if.master   fifo,
    output logic        busy,
    output logic        done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [31:0]   Z_DIR    = ~(32'd1 << Q_BITS) + 32'd1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic          wr;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [31:0]   cur_x;
    logic [31:0]   cur_y;
    logic [31:0]   step_q;
    logic [31:0]   dx;
    logic          last_px;

    assign last_px = (col == COL_LAST) && (row == ROW_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        wr       = 1'b0;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                wr = !fifo.full;
                if (wr && last_px) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef RAY_GEN_SERPENTINE_EN
    // dir=1 on odd rows: walk back from where the previous row ended
    logic dir;

    assign dx = dir ? (32'd0 - step_q) : step_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dir <= 1'b0;
        end else if (state == IDLE && start) begin
            dir <= 1'b0;
        end else if (wr && col == COL_LAST) begin
            dir <= ~dir;
        end
    end
`else
    logic [31:0] x0_q;

    assign dx = step_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x0_q <= '0;
        end else if (state == IDLE && start) begin
            x0_q <= x_start;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col    <= '0;
            row    <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
            step_q <= '0;
        end else if (state == IDLE && start) begin
            col    <= '0;
            row    <= '0;
            cur_x  <= x_start;
            cur_y  <= y_start;
            step_q <= step;
        end else if (wr) begin
            if (col != COL_LAST) begin
                col   <= col + 1'b1;
                cur_x <= cur_x + dx;
            end else begin
                col   <= '0;
                row   <= row + 1'b1;
                cur_y <= cur_y - step_q;
`ifndef RAY_GEN_SERPENTINE_EN
                cur_x <= x0_q;
`endif
            end
        end
    end

    always_comb begin
        fifo.wr_en   = wr;
        fifo.dout[0] = cur_x;
        fifo.dout[1] = cur_y;
        fifo.dout[2] = Z_DIR;
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_ray_gen.sv
// Self-checking bench for ray_gen: randomized stimulus against a
// closed-form per-pixel reference model.
module tb_ray_gen;

    localparam int W = 4;
    localparam int H = 2;
    localparam int Q = 10;
    localparam logic [31:0] ZD = 32'hFFFFFC00;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] x_start;
    logic [31:0] y_start;
    logic [31:0] step;
    logic        busy;
    logic        done;

    ray_gen_if bus ();

    ray_gen #(
        .Q_BITS(Q),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .x_start(x_start),
        .y_start(y_start),
        .step   (step),
        .fifo   (bus.master),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [95:0] wq[$];
    int          wc[$];
    int          cyc  = 0;
    int          dn   = 0;
    int          viol = 0;

    always @(posedge clock) begin
        cyc = cyc + 1;
        if (bus.wr_en === 1'b1) begin
            if (bus.full !== 1'b0) viol = viol + 1;
            wq.push_back({bus.dout[0], bus.dout[1], bus.dout[2]});
            wc.push_back(cyc);
        end
        if (done === 1'b1) dn = dn + 1;
    end

    // Pixel idx in scan order -> expected {x,y,z}, straight from geometry
    function automatic logic [95:0] model(int idx, logic [31:0] x0,
                                          logic [31:0] y0, logic [31:0] st);
        int r;
        int c;
        int pos;
        logic [31:0] x;
        logic [31:0] y;
        r   = (idx / W) % H;
        c   = idx % W;
        pos = c;
`ifdef RAY_GEN_SERPENTINE_EN
        if (r % 2 == 1) pos = W - 1 - c;
`endif
        x = x0 + 32'(pos) * st;
        y = y0 - 32'(r) * st;
        return {x, y, ZD};
    endfunction

    task automatic clear();
        wq.delete();
        wc.delete();
        dn   = 0;
        viol = 0;
    endtask

    task automatic start_frame(logic [31:0] x0, logic [31:0] y0,
                               logic [31:0] st);
        @(negedge clock);
        x_start = x0;
        y_start = y0;
        step    = st;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        x_start = $urandom;
        y_start = $urandom;
        step    = $urandom;
    endtask

    task automatic run_until_done(int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_writes(int n, int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (wq.size() >= n) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        bus.full = 1'b0;
        x_start  = '0;
        y_start  = '0;
        step     = '0;
        #1;
        tests++;
        if (bus.wr_en !== 1'b0) begin
            fails++; $display("FAIL rst_wr_en got %b want 0", bus.wr_en);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL rst_busy got %b want 0", busy);
        end
        tests++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL rst_done got %b want 0", done);
        end
        tests++;
        if (bus.dout[0] !== 32'h0) begin
            fails++; $display("FAIL rst_x got %h want 0", bus.dout[0]);
        end
        tests++;
        if (bus.dout[1] !== 32'h0) begin
            fails++; $display("FAIL rst_y got %h want 0", bus.dout[1]);
        end
        tests++;
        if (bus.dout[2] !== ZD) begin
            fails++; $display("FAIL rst_z got %h want %h", bus.dout[2], ZD);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_raster();
        bit ok;
        clear();
        start_frame(32'hFFFFFA00, 32'h00000200, 32'h00000400);
        run_until_done(100, ok);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL raster_done_timeout got 0 want 1");
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL raster_busy_in_done got %b want 0", busy);
        end
        repeat (3) @(negedge clock);
        tests++;
        if (wq.size() != W * H) begin
            fails++; $display("FAIL raster_count got %0d want %0d", wq.size(), W * H);
        end
        for (int i = 0; i < wq.size(); i++) begin
            logic [95:0] e;
            e = model(i, 32'hFFFFFA00, 32'h00000200, 32'h00000400);
            tests++;
            if (wq[i] !== e) begin
                fails++; $display("FAIL raster_vec%0d got %h want %h", i, wq[i], e);
            end
        end
        tests++;
        if (dn != 1) begin
            fails++; $display("FAIL raster_done_pulses got %0d want 1", dn);
        end
        tests++;
        if (wc.size() == W * H && wc[W*H-1] - wc[0] != W * H - 1) begin
            fails++; $display("FAIL raster_throughput got %0d want %0d",
                              wc[W*H-1] - wc[0], W * H - 1);
        end
        tests++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL raster_done_low got %b want 0", done);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear();
        start_frame(32'hFFFFFA00, 32'h00000200, 32'h00000400);
        wait_writes(2, 50, ok);
        bus.full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (bus.wr_en !== 1'b0 || wq.size() != 2) begin
                fails++; $display("FAIL bp_stall%0d got wr_en=%b n=%0d want 0/2",
                                  k, bus.wr_en, wq.size());
            end
            @(negedge clock);
        end
        bus.full = 1'b0;
        run_until_done(100, ok);
        repeat (2) @(negedge clock);
        tests++;
        if (wq.size() != W * H) begin
            fails++; $display("FAIL bp_count got %0d want %0d", wq.size(), W * H);
        end
        tests++;
        if (wq.size() > 2 && wq[2] !== {32'h00000200, 32'h00000200, ZD}) begin
            fails++; $display("FAIL bp_write3 got %h", wq[2]);
        end
        for (int i = 0; i < wq.size(); i++) begin
            logic [95:0] e;
            e = model(i, 32'hFFFFFA00, 32'h00000200, 32'h00000400);
            tests++;
            if (wq[i] !== e) begin
                fails++; $display("FAIL bp_vec%0d got %h want %h", i, wq[i], e);
            end
        end
        tests++;
        if (viol != 0) begin
            fails++; $display("FAIL bp_write_while_full got %0d want 0", viol);
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        clear();
        start_frame(32'h00001000, 32'hFFFFF000, 32'h00000123);
        wait_writes(3, 50, ok);
        start   = 1'b1;
        x_start = 32'h7FFF0000;
        @(negedge clock);
        start   = 1'b0;
        run_until_done(100, ok);
        repeat (10) @(negedge clock);
        tests++;
        if (wq.size() != W * H) begin
            fails++; $display("FAIL ign_count got %0d want %0d", wq.size(), W * H);
        end
        tests++;
        if (dn != 1 || busy !== 1'b0) begin
            fails++; $display("FAIL ign_restart got dn=%0d busy=%b want 1/0", dn, busy);
        end
        for (int i = 0; i < wq.size(); i++) begin
            logic [95:0] e;
            e = model(i, 32'h00001000, 32'hFFFFF000, 32'h00000123);
            tests++;
            if (wq[i] !== e) begin
                fails++; $display("FAIL ign_vec%0d got %h want %h", i, wq[i], e);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        clear();
        start_frame(32'hFFFFFA00, 32'h00000200, 32'h00000400);
        wait_writes(3, 50, ok);
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (bus.wr_en !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL arst_immediate got wr_en=%b busy=%b want 0/0",
                              bus.wr_en, busy);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        tests++;
        if (dn != 0 || wq.size() != 3) begin
            fails++; $display("FAIL arst_abandon got dn=%0d n=%0d want 0/3", dn, wq.size());
        end
        clear();
        start_frame(32'h00000400, 32'h00000800, 32'hFFFFFF00);
        run_until_done(100, ok);
        repeat (2) @(negedge clock);
        tests++;
        if (wq.size() != W * H) begin
            fails++; $display("FAIL arst_count got %0d want %0d", wq.size(), W * H);
        end
        for (int i = 0; i < wq.size(); i++) begin
            logic [95:0] e;
            e = model(i, 32'h00000400, 32'h00000800, 32'hFFFFFF00);
            tests++;
            if (wq[i] !== e) begin
                fails++; $display("FAIL arst_vec%0d got %h want %h", i, wq[i], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit up;
        clear();
        start_frame(32'hFFFFFA00, 32'h00000200, 32'h00000400);
        run_until_done(100, ok);
        x_start = 32'hFFFFFA00;
        y_start = 32'h00000200;
        step    = 32'h00000400;
        start   = 1'b1;
        up      = 1'b0;
        for (int i = 0; i < 5 && !up; i++) begin
            @(negedge clock);
            if (busy === 1'b1) up = 1'b1;
        end
        start = 1'b0;
        tests++;
        if (!up) begin
            fails++; $display("FAIL b2b_restart got busy=0 want 1");
        end
        run_until_done(100, ok);
        repeat (3) @(negedge clock);
        tests++;
        if (wq.size() != 2 * W * H || dn != 2) begin
            fails++; $display("FAIL b2b_count got n=%0d dn=%0d want %0d/2",
                              wq.size(), dn, 2 * W * H);
        end
        for (int i = 0; i < wq.size(); i++) begin
            logic [95:0] e;
            e = model(i, 32'hFFFFFA00, 32'h00000200, 32'h00000400);
            tests++;
            if (wq[i] !== e) begin
                fails++; $display("FAIL b2b_vec%0d got %h want %h", i, wq[i], e);
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            logic [31:0] x0;
            logic [31:0] y0;
            logic [31:0] st;
            bit ok;
            clear();
            x0 = $urandom;
            y0 = $urandom;
            st = $urandom;
            start_frame(x0, y0, st);
            ok = 1'b0;
            for (int i = 0; i < 400 && !ok; i++) begin
                bus.full = ($urandom_range(0, 2) == 0);
                @(negedge clock);
                if (done === 1'b1) ok = 1'b1;
            end
            bus.full = 1'b0;
            repeat (2) @(negedge clock);
            tests++;
            if (!ok || wq.size() != W * H || viol != 0) begin
                fails++; $display("FAIL rnd%0d_frame got ok=%0d n=%0d viol=%0d",
                                  f, ok, wq.size(), viol);
            end
            for (int i = 0; i < wq.size(); i++) begin
                logic [95:0] e;
                e = model(i, x0, y0, st);
                tests++;
                if (wq[i] !== e) begin
                    fails++; $display("FAIL rnd%0d_vec%0d got %h want %h",
                                      f, i, wq[i], e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_backpressure();
        test_start_ignored();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
